// File: rtl/cpu_pio_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pio_pkg
// Shared constants for the pulse-capable output PIO: register word addresses
// and STATUS bit positions. Imported by cpu_pio_out_pulse.
// -----------------------------------------------------------------------------
package cpu_pio_pkg;

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_OUTSET    = 3'd2;
   localparam logic [2:0] ADDR_OUTCLEAR  = 3'd3;
   localparam logic [2:0] ADDR_PULSE     = 3'd4;
   localparam logic [2:0] ADDR_PULSE_LEN = 3'd5;
   localparam logic [2:0] ADDR_STATUS    = 3'd6;

   localparam int STATUS_BUSY_BIT = 0;

endpackage

// File: rtl/cpu_pio_pulse_timer.sv
// -----------------------------------------------------------------------------
// cpu_pio_pulse_timer
// One-shot pulse engine. A trigger ORs trig_mask into the held pulse mask and
// (re)loads the down-counter with len; the mask is released on the edge where
// the counter reaches zero, so the mask bits stay high for exactly len cycles
// after the last trigger.
//
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   trigger       : qualified trigger (caller guarantees trig_mask != 0, len != 0)
//   trig_mask     : bits to force high
//   len           : pulse length in clocks
//   pulse_mask    : bits currently forced high (registered)
//   busy          : counter non-zero
// -----------------------------------------------------------------------------
module cpu_pio_pulse_timer #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  trigger,
   input  logic [DATA_WIDTH-1:0] trig_mask,
   input  logic [CNT_W-1:0]      len,
   output logic [DATA_WIDTH-1:0] pulse_mask,
   output logic                  busy
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         pulse_mask <= '0;
      end else if (trigger) begin
         // Retrigger extends the shared window for every bit already held.
         pulse_mask <= pulse_mask | trig_mask;
         cnt        <= len;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            pulse_mask <= '0;
         end
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/cpu_pio_out_pulse.sv
// -----------------------------------------------------------------------------
// cpu_pio_out_pulse
// Avalon-MM output PIO with atomic bit set/clear and a hardware one-shot pulse
// engine. out_port is the OR of the DATA register and the active pulse mask,
// both registered, so the bus never reaches the pins combinationally.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   address      : register word address (3 bits)
//   chipselect   : slave select
//   write_n      : active-low write strobe
//   writedata    : 32-bit write data
//   readdata     : 32-bit read data, combinational from address
//   out_port     : DATA_WIDTH pin outputs
//   busy         : pulse in progress
// -----------------------------------------------------------------------------
module cpu_pio_out_pulse
   import cpu_pio_pkg::*;
#(
   parameter int                    DATA_WIDTH      = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
   parameter int                    CNT_W           = 16,
   parameter logic [CNT_W-1:0]      PULSE_LEN_RESET = CNT_W'(1000)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  busy
);

   logic                  wr;
   logic [DATA_WIDTH-1:0] wd;
   logic [DATA_WIDTH-1:0] data_q;
   logic [CNT_W-1:0]      pulse_len_q;
   logic [DATA_WIDTH-1:0] pulse_mask;
   logic                  trigger;
   logic                  unused_wd;

   assign wr = chipselect & ~write_n;
   assign wd = writedata[DATA_WIDTH-1:0];

   // Upper writedata bits are ignored for narrow configurations.
   assign unused_wd = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= RESET_VALUE;
      end else if (wr) begin
         case (address)
            ADDR_DATA:     data_q <= wd;
            ADDR_OUTSET:   data_q <= data_q | wd;
            ADDR_OUTCLEAR: data_q <= data_q & ~wd;
            default:       data_q <= data_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pulse_len_q <= PULSE_LEN_RESET;
      end else if (wr && (address == ADDR_PULSE_LEN)) begin
         pulse_len_q <= writedata[CNT_W-1:0];
      end
   end

   // An empty mask or a zero length would be a no-op pulse; suppress it so
   // it cannot reload or clear a pulse already in flight.
   assign trigger = wr && (address == ADDR_PULSE) &&
                    (wd != '0) && (pulse_len_q != '0);

   cpu_pio_pulse_timer #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_W      (CNT_W)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .trigger    (trigger),
      .trig_mask  (wd),
      .len        (pulse_len_q),
      .pulse_mask (pulse_mask),
      .busy       (busy)
   );

   assign out_port = data_q | pulse_mask;

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:      readdata[DATA_WIDTH-1:0] = data_q;
         ADDR_PULSE_LEN: readdata[CNT_W-1:0]      = pulse_len_q;
         ADDR_STATUS:    readdata[STATUS_BUSY_BIT] = busy;
         default:        readdata = '0;
      endcase
   end

endmodule
